dog_builder: RTL and testbench

DOG_BUILDER -- requirements
Module: dog_builder

---
 rtl/dog_builder.sv | 163 ++++++++++++++++
 tb/tb_dog_builder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dog_builder.sv
`default_nettype none
// ============================================================================
//  Module   : dog_builder
//  Brief    : Streams two equally sized source images out of a shared BRAM
//             address and writes their signed difference (hi - lo) as one
//             difference-of-Gaussians image.
//  Revision : 1.0  initial release
// ============================================================================
module dog_builder #(
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int BIT_DEPTH = 8,
  parameter int RD_LAT    = 2,
  localparam int N        = IMG_W * IMG_H,
  localparam int ADDR_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 hold_in,
  output logic [ADDR_W-1:0]    rd_addr_out,
  output logic                 rd_en_out,
  input  logic [BIT_DEPTH-1:0] pix_lo_in,
  input  logic [BIT_DEPTH-1:0] pix_hi_in,
  output logic [ADDR_W-1:0]    wr_addr_out,
  output logic [BIT_DEPTH:0]   wr_data_out,
  output logic                 wr_valid_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     r_wr_cnt;
  logic                  r_dl_vld  [RD_LAT];
  logic [ADDR_W-1:0]     r_dl_addr [RD_LAT];
  logic [ADDR_W-1:0]     r_last_addr;
  logic [BIT_DEPTH:0]    r_last_data;
  logic                  w_rd_en;
  logic                  w_wr_valid;
  logic                  w_busy;
  logic                  w_done;
  logic [BIT_DEPTH:0]    w_diff;

  // The oldest delay-line stage lines up with the BRAM data for that read.
  assign w_wr_valid = r_dl_vld[RD_LAT-1];
  // Exact difference of zero-extended operands; the extra bit carries the sign.
  assign w_diff     = {1'b0, pix_hi_in} - {1'b0, pix_lo_in};

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the state-derived strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_busy  = 1'b1;
        w_rd_en = !hold_in;
        if (w_rd_en && (r_addr == c_LAST_ADDR)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_wr_valid && (r_wr_cnt == c_LAST_ADDR)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Raster read address: parked at 0 outside RUN, saturates at N-1.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_addr <= '0;
    end else if (r_state != S_RUN) begin
      r_addr <= '0;
    end else if (w_rd_en && (r_addr != c_LAST_ADDR)) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Count writes so the drain knows when the final pixel has gone out.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_wr_cnt <= '0;
    end else if (w_wr_valid && (r_wr_cnt != c_LAST_ADDR)) begin
      r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
    end
  end

  // Delay line carrying read valid and address across the BRAM latency.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_dl_vld[i]  <= 1'b0;
        r_dl_addr[i] <= '0;
      end
    end else begin
      r_dl_vld[0]  <= w_rd_en;
      r_dl_addr[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_dl_vld[i]  <= r_dl_vld[i-1];
        r_dl_addr[i] <= r_dl_addr[i-1];
      end
    end
  end

  // Remember the last write so the write bus holds steady between strobes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_last_addr <= '0;
      r_last_data <= '0;
    end else if (w_wr_valid) begin
      r_last_addr <= r_dl_addr[RD_LAT-1];
      r_last_data <= w_diff;
    end
  end

  assign rd_addr_out  = r_addr;
  assign rd_en_out    = w_rd_en;
  assign wr_valid_out = w_wr_valid;
  assign wr_addr_out  = w_wr_valid ? r_dl_addr[RD_LAT-1] : r_last_addr;
  assign wr_data_out  = w_wr_valid ? w_diff : r_last_data;
  assign busy_out     = w_busy;
  assign done_out     = w_done;

endmodule
`default_nettype wire

// File: tb/tb_dog_builder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dog_builder
//  Brief    : Scoreboard bench for dog_builder on a 4x4 image with a
//             two-cycle BRAM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dog_builder;

  localparam int IMG_W     = 4;
  localparam int IMG_H     = 4;
  localparam int BIT_DEPTH = 8;
  localparam int RD_LAT    = 2;
  localparam int N         = IMG_W * IMG_H;
  localparam int ADDR_W    = $clog2(N);
  localparam int NONE      = 1000;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 start_in = 1'b0;
  logic                 hold_in = 1'b0;
  logic [ADDR_W-1:0]    rd_addr_out;
  logic                 rd_en_out;
  logic [BIT_DEPTH-1:0] pix_lo_in;
  logic [BIT_DEPTH-1:0] pix_hi_in;
  logic [ADDR_W-1:0]    wr_addr_out;
  logic [BIT_DEPTH:0]   wr_data_out;
  logic                 wr_valid_out;
  logic                 busy_out;
  logic                 done_out;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t           q[$];
  logic [7:0]     lo_mem [N];
  logic [7:0]     hi_mem [N];
  logic [7:0]     r_lo1, r_lo2, r_hi1, r_hi2;
  int             checks = 0;
  int             errors = 0;
  int             wr_seen = 0;

  dog_builder #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BIT_DEPTH(BIT_DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .hold_in(hold_in),
    .rd_addr_out(rd_addr_out), .rd_en_out(rd_en_out),
    .pix_lo_in(pix_lo_in), .pix_hi_in(pix_hi_in),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .wr_valid_out(wr_valid_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  // Two-cycle BRAM model shared by both images.
  always @(posedge clk_in) begin
    r_lo1 <= lo_mem[rd_addr_out];
    r_hi1 <= hi_mem[rd_addr_out];
    r_lo2 <= r_lo1;
    r_hi2 <= r_hi1;
  end
  assign pix_lo_in = r_lo2;
  assign pix_hi_in = r_hi2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input logic [8:0] d);
    exp_t e;
    e.addr = a;
    e.data = {23'd0, d};
    q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},    {31'd0, rd_en_out},    0);
    chk({tag, "_rd_addr"},  {28'd0, rd_addr_out},  0);
    chk({tag, "_wr_valid"}, {31'd0, wr_valid_out}, 0);
    chk({tag, "_wr_addr"},  {28'd0, wr_addr_out},  0);
    chk({tag, "_wr_data"},  {23'd0, wr_data_out},  0);
    chk({tag, "_busy"},     {31'd0, busy_out},     0);
    chk({tag, "_done"},     {31'd0, done_out},     0);
  endtask

  // One start pulse; hold_in high for cycles hold_k..hold_k+2 after the
  // start edge, optional spurious start in cycle spur_k.
  task automatic run_one(input int hold_k, input int spur_k, input int exp_done);
    int k;
    bit seen;
    @(negedge clk_in);
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    chk("first_rd_en",   {31'd0, rd_en_out},   1);
    chk("first_rd_addr", {28'd0, rd_addr_out}, 0);
    chk("first_busy",    {31'd0, busy_out},    1);
    k = 1;
    seen = 1'b0;
    while (!seen && k < 100) begin
      if (done_out) begin
        seen = 1'b1;
        chk("done_latency", k, exp_done);
        chk("busy_at_done", {31'd0, busy_out}, 0);
      end else begin
        @(posedge clk_in);
        #1;
        k++;
        hold_in  = (k >= hold_k) && (k < hold_k + 3);
        start_in = (k == spur_k);
        #1;
        if (hold_in) begin
          chk("rd_en_hold",   {31'd0, rd_en_out},   0);
          chk("rd_addr_hold", {28'd0, rd_addr_out}, hold_k - 1);
        end
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    hold_in  = 1'b0;
    start_in = 1'b0;
    @(posedge clk_in);
    #1 chk("done_single", {31'd0, done_out}, 0);
    chk("writes_all_consumed", q.size(), 0);
  endtask

  initial begin
    int base;
    int pend;
    int k;
    exp_t e;
    logic [31:0] last_a;
    logic [31:0] last_d;

    for (int i = 0; i < N; i++) begin
      lo_mem[i] = 8'(i);
      hi_mem[i] = 8'(2 * i);
    end

    // Write-side monitor: pops the scoreboard whenever the DUT writes.
    fork
      begin
        last_a = 0;
        last_d = 0;
        forever begin
          @(negedge clk_in);
          if (!rst_in) begin
            last_a = 0;
            last_d = 0;
          end else if (wr_valid_out) begin
            if (q.size() == 0) begin
              chk("unexpected_write", {28'd0, wr_addr_out}, 32'hFFFF_FFFF);
            end else begin
              e = q.pop_front();
              chk("wr_addr", {28'd0, wr_addr_out}, e.addr);
              chk("wr_data", {23'd0, wr_data_out}, e.data);
            end
            last_a = {28'd0, wr_addr_out};
            last_d = {23'd0, wr_data_out};
            wr_seen++;
          end else begin
            chk("wr_addr_idle_hold", {28'd0, wr_addr_out}, last_a);
            chk("wr_data_idle_hold", {23'd0, wr_data_out}, last_d);
          end
        end
      end
    join_none

    // Reset state.
    repeat (2) @(posedge clk_in);
    #1 chk_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;

    // Nominal: data = 2i - i = i.
    for (int i = 0; i < N; i++) push(i, 9'(i));
    run_one(NONE, NONE, 19);

    // Sign and extremes: lo=10, hi=i except addresses 3 and 4.
    for (int i = 0; i < N; i++) begin
      lo_mem[i] = 8'd10;
      hi_mem[i] = 8'(i);
    end
    lo_mem[3] = 8'd255; hi_mem[3] = 8'd0;
    lo_mem[4] = 8'd0;   hi_mem[4] = 8'd255;
    for (int i = 0; i < N; i++) begin
      if (i == 3)      push(i, 9'h101);
      else if (i == 4) push(i, 9'h0FF);
      else             push(i, 9'(i - 10));
    end
    run_one(NONE, NONE, 19);

    // Hold for three cycles after address 5 issues.
    for (int i = 0; i < N; i++) begin
      lo_mem[i] = 8'(i);
      hi_mem[i] = 8'(2 * i);
    end
    for (int i = 0; i < N; i++) push(i, 9'(i));
    run_one(7, NONE, 22);

    // Spurious start while busy, then confirm no second run appears.
    for (int i = 0; i < N; i++) push(i, 9'(i));
    run_one(NONE, 5, 19);
    base = wr_seen;
    repeat (30) @(posedge clk_in);
    #1 chk("no_second_run_busy", {31'd0, busy_out}, 0);
    chk("no_second_run_writes", wr_seen - base, 0);

    // Reset after seven writes of a run.
    for (int i = 0; i < N; i++) push(i, 9'(i));
    base = wr_seen;
    @(negedge clk_in);
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    k = 0;
    while ((wr_seen - base) < 7 && k < 50) begin
      @(posedge clk_in);
      #1;
      k++;
    end
    chk("writes_before_reset", wr_seen - base, 7);
    rst_in = 1'b0;
    #1 chk_all_zero("midrun_reset");
    pend = q.size();
    chk("pending_after_reset", pend, 9);
    q.delete();
    repeat (3) @(posedge clk_in);
    #1 chk_all_zero("held_reset");
    rst_in = 1'b1;
    for (int i = 0; i < N; i++) push(i, 9'(i));
    run_one(NONE, NONE, 19);

    repeat (5) @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
